id_ex_stage: RTL and testbench

//  ID/EX pipeline register with integrated load-use hazard detection.

---
 rtl/id_ex_stage.sv | 106 ++++++++++
 tb/tb_id_ex_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose destination feeds the instruction in ID forces a bubble
// into EX and stalls the front end for one cycle. Flush kills the ID
// instruction, and Hold freezes the register for downstream stalls.
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_PC,
  input  logic [DATA_W-1:0]     id_RD1,
  input  logic [DATA_W-1:0]     id_RD2,
  input  logic [DATA_W-1:0]     id_Imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [2:0]            id_Funct3,
  input  logic [6:0]            id_Funct7,
  input  logic [1:0]            id_ALUOp,
  input  logic [6:0]            id_Ctrl,
  input  logic                  Flush,
  input  logic                  Hold,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_PC,
  output logic [DATA_W-1:0]     ex_RD1,
  output logic [DATA_W-1:0]     ex_RD2,
  output logic [DATA_W-1:0]     ex_Imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [2:0]            ex_Funct3,
  output logic [6:0]            ex_Funct7,
  output logic [1:0]            ex_ALUOp,
  output logic [6:0]            ex_Ctrl,
  output logic                  HazardStall,
  output logic [CNT_W-1:0]      BubbleCount
);

  // Control bundle layout: {ALUSrc,MemRead,MemWrite,RegWrite,MemtoReg,Branch,Jump}
  localparam int CTRL_ALUSRC   = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;

  logic uses_rs2;
  logic ex_is_load;
  logic hazard;
  logic load_bubble;

  // Load-use detection; rs1 is always treated as a source (conservative for
  // LUI/AUIPC/JAL), rs2 only when the ALU or a store actually consumes it.
  always_comb begin
    uses_rs2   = ~id_Ctrl[CTRL_ALUSRC] | id_Ctrl[CTRL_MEMWRITE];
    ex_is_load = ex_valid & ex_Ctrl[CTRL_MEMREAD] & (ex_rd != '0);
    hazard     = id_valid & ex_is_load &
                 ((ex_rd == id_rs1) | (uses_rs2 & (ex_rd == id_rs2)));
  end

  assign HazardStall = hazard & ~Flush & ~Hold;

  // A flush always empties EX; a hazard only does so when not held.
  assign load_bubble = Flush | (hazard & ~Hold);

  // Pipeline register: reset/bubble clears every field, Hold retains.
  always_ff @(posedge clk) begin
    if (reset || load_bubble) begin
      ex_valid  <= 1'b0;
      ex_PC     <= '0;
      ex_RD1    <= '0;
      ex_RD2    <= '0;
      ex_Imm    <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_Funct3 <= '0;
      ex_Funct7 <= '0;
      ex_ALUOp  <= '0;
      ex_Ctrl   <= '0;
    end else if (!Hold) begin
      ex_valid  <= id_valid;
      ex_PC     <= id_PC;
      ex_RD1    <= id_RD1;
      ex_RD2    <= id_RD2;
      ex_Imm    <= id_Imm;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      ex_rd     <= id_rd;
      ex_Funct3 <= id_Funct3;
      ex_Funct7 <= id_Funct7;
      ex_ALUOp  <= id_ALUOp;
      ex_Ctrl   <= id_Ctrl;
    end
  end

  // Saturating count of hazard bubbles; flush bubbles are not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      BubbleCount <= '0;
    end else if (HazardStall && (BubbleCount != '1)) begin
      BubbleCount <= BubbleCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  localparam logic [6:0] C_ADD  = 7'b0001000;
  localparam logic [6:0] C_ADDI = 7'b1001000;
  localparam logic [6:0] C_LW   = 7'b1101100;

  logic clk = 1'b0;
  logic reset, id_valid, Flush, Hold;
  logic [DW-1:0] id_PC, id_RD1, id_RD2, id_Imm;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic [2:0] id_Funct3;
  logic [6:0] id_Funct7, id_Ctrl;
  logic [1:0] id_ALUOp;

  logic ex_valid, HazardStall;
  logic [DW-1:0] ex_PC, ex_RD1, ex_RD2, ex_Imm;
  logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_Funct3;
  logic [6:0] ex_Funct7, ex_Ctrl;
  logic [1:0] ex_ALUOp;
  logic [15:0] BubbleCount;

  logic s_valid, s_stall;
  logic [DW-1:0] s_PC, s_RD1, s_RD2, s_Imm;
  logic [AW-1:0] s_rs1, s_rs2, s_rd;
  logic [2:0] s_Funct3;
  logic [6:0] s_Funct7, s_Ctrl;
  logic [1:0] s_ALUOp;
  logic [1:0] s_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_PC(id_PC),
    .id_RD1(id_RD1), .id_RD2(id_RD2), .id_Imm(id_Imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_Funct3(id_Funct3), .id_Funct7(id_Funct7),
    .id_ALUOp(id_ALUOp), .id_Ctrl(id_Ctrl), .Flush(Flush), .Hold(Hold),
    .ex_valid(ex_valid), .ex_PC(ex_PC), .ex_RD1(ex_RD1), .ex_RD2(ex_RD2),
    .ex_Imm(ex_Imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_Funct3(ex_Funct3), .ex_Funct7(ex_Funct7), .ex_ALUOp(ex_ALUOp),
    .ex_Ctrl(ex_Ctrl), .HazardStall(HazardStall), .BubbleCount(BubbleCount)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  id_ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_PC(id_PC),
    .id_RD1(id_RD1), .id_RD2(id_RD2), .id_Imm(id_Imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_Funct3(id_Funct3), .id_Funct7(id_Funct7),
    .id_ALUOp(id_ALUOp), .id_Ctrl(id_Ctrl), .Flush(Flush), .Hold(Hold),
    .ex_valid(s_valid), .ex_PC(s_PC), .ex_RD1(s_RD1), .ex_RD2(s_RD2),
    .ex_Imm(s_Imm), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
    .ex_Funct3(s_Funct3), .ex_Funct7(s_Funct7), .ex_ALUOp(s_ALUOp),
    .ex_Ctrl(s_Ctrl), .HazardStall(s_stall), .BubbleCount(s_cnt)
  );

  // Model view of the EX stage as one record of everything ID handed over.
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc, rd1, rd2, imm;
    logic [AW-1:0] rs1, rs2, rd;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [1:0]    aluop;
    logic [6:0]    ctrl;
  } stage_t;

  stage_t      m;
  int unsigned m_cnt, m_cnt2;
  bit          check_en = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  wire stage_t dut_stage = {ex_valid, ex_PC, ex_RD1, ex_RD2, ex_Imm, ex_rs1,
                            ex_rs2, ex_rd, ex_Funct3, ex_Funct7, ex_ALUOp, ex_Ctrl};
  wire stage_t sat_stage = {s_valid, s_PC, s_RD1, s_RD2, s_Imm, s_rs1,
                            s_rs2, s_rd, s_Funct3, s_Funct7, s_ALUOp, s_Ctrl};

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Does the instruction now in ID read the register a load in EX will write?
  function automatic bit model_hazard();
    bit load_in_ex, reads_rs2;
    load_in_ex = m.valid && m.ctrl[5] && (m.rd != 0);
    reads_rs2  = !id_Ctrl[6] || id_Ctrl[4];
    return id_valid && load_in_ex &&
           ((m.rd == id_rs1) || (reads_rs2 && (m.rd == id_rs2)));
  endfunction

  // Model advance on each clock: reset > flush > hold > hazard > pass.
  always @(posedge clk) begin
    if (reset) begin
      m = '0; m_cnt = 0; m_cnt2 = 0;
    end else if (Flush) begin
      m = '0;
    end else if (Hold) begin
      m = m;
    end else if (model_hazard()) begin
      m = '0;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end else begin
      m = {id_valid, id_PC, id_RD1, id_RD2, id_Imm, id_rs1, id_rs2, id_rd,
           id_Funct3, id_Funct7, id_ALUOp, id_Ctrl};
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      chk("ex_stage", 192'(dut_stage), 192'(m));
      chk("ex_stage_sat", 192'(sat_stage), 192'(m));
      chk("HazardStall", 192'(HazardStall), 192'(model_hazard() && !Flush && !Hold));
      chk("HazardStall_sat", 192'(s_stall), 192'(model_hazard() && !Flush && !Hold));
      chk("BubbleCount", 192'(BubbleCount), 192'(m_cnt));
      chk("BubbleCount_sat", 192'(s_cnt), 192'(m_cnt2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_id();
    id_valid  = ($urandom_range(0, 9) != 0);
    id_PC     = $urandom;
    id_RD1    = $urandom;
    id_RD2    = $urandom;
    id_Imm    = $urandom;
    id_rs1    = 5'($urandom_range(0, 7));
    id_rs2    = 5'($urandom_range(0, 7));
    id_rd     = 5'($urandom_range(0, 7));
    id_Funct3 = 3'($urandom);
    id_Funct7 = 7'($urandom);
    id_ALUOp  = 2'($urandom);
    id_Ctrl   = 7'($urandom);
  endtask

  task automatic set_id(input logic [DW-1:0] pc, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                        input logic [1:0] aluop, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [6:0] ctrl);
    rand_id();
    id_valid = 1'b1; id_PC = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_ALUOp = aluop; id_Funct3 = f3; id_Funct7 = f7; id_Ctrl = ctrl;
  endtask

  // Directed scenarios, then randomized traffic.
  initial begin
    reset = 1'b1; Flush = 1'b0; Hold = 1'b0;
    rand_id();
    tick();
    check_en = 1'b1;
    rand_id();
    tick();
    chk("reset_ex_stage", 192'(dut_stage), 192'(0));
    chk("reset_BubbleCount", 192'(BubbleCount), 192'(0));
    chk("reset_HazardStall", 192'(HazardStall), 192'(0));

    reset = 1'b0;
    set_id(32'h100, 5'd1, 5'd2, 5'd3, 2'b10, 3'b000, 7'h20, C_ADD);
    tick();
    chk("pass_ex_PC", 192'(ex_PC), 192'(32'h100));
    chk("pass_ex_Funct7", 192'(ex_Funct7), 192'(7'h20));
    chk("pass_ex_valid", 192'(ex_valid), 192'(1));

    set_id(32'h104, 5'd1, 5'd1, 5'd5, 2'b00, 3'b010, 7'h00, C_LW);
    #1 chk("lw_enter_stall", 192'(HazardStall), 192'(0));
    tick();
    set_id(32'h108, 5'd1, 5'd5, 5'd6, 2'b10, 3'b000, 7'h00, C_ADD);
    #1 chk("loaduse_stall", 192'(HazardStall), 192'(1));
    tick();
    chk("loaduse_bubble_valid", 192'(ex_valid), 192'(0));
    chk("loaduse_bubble_ctrl", 192'(ex_Ctrl), 192'(0));
    chk("loaduse_count", 192'(BubbleCount), 192'(1));
    #1 chk("after_bubble_stall", 192'(HazardStall), 192'(0));
    tick();
    chk("stalled_add_PC", 192'(ex_PC), 192'(32'h108));
    chk("stalled_add_valid", 192'(ex_valid), 192'(1));

    set_id(32'h10c, 5'd0, 5'd0, 5'd0, 2'b00, 3'b010, 7'h00, C_LW);
    tick();
    set_id(32'h110, 5'd0, 5'd0, 5'd4, 2'b10, 3'b000, 7'h00, C_ADD);
    #1 chk("x0_no_stall", 192'(HazardStall), 192'(0));
    set_id(32'h110, 5'd1, 5'd1, 5'd7, 2'b00, 3'b010, 7'h00, C_LW);
    tick();
    set_id(32'h114, 5'd1, 5'd7, 5'd8, 2'b10, 3'b000, 7'h00, C_ADDI);
    #1 chk("imm_no_stall", 192'(HazardStall), 192'(0));
    tick();

    set_id(32'h118, 5'd1, 5'd1, 5'd9, 2'b00, 3'b010, 7'h00, C_LW);
    tick();
    set_id(32'h11c, 5'd9, 5'd2, 5'd10, 2'b10, 3'b000, 7'h00, C_ADD);
    Flush = 1'b1;
    #1 chk("flush_masks_stall", 192'(HazardStall), 192'(0));
    tick();
    Flush = 1'b0;
    chk("flush_bubble_valid", 192'(ex_valid), 192'(0));
    chk("flush_count", 192'(BubbleCount), 192'(1));
    set_id(32'h200, 5'd1, 5'd2, 5'd3, 2'b10, 3'b000, 7'h00, C_ADD);
    tick();
    Hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      tick();
      chk("hold_ex_PC", 192'(ex_PC), 192'(32'h200));
      chk("hold_ex_valid", 192'(ex_valid), 192'(1));
    end
    Hold = 1'b0;

    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_id(32'h300, 5'd1, 5'd1, 5'd10, 2'b00, 3'b010, 7'h00, C_LW);
      tick();
      set_id(32'h304, 5'd10, 5'd2, 5'd11, 2'b10, 3'b000, 7'h00, C_ADD);
      tick();
    end
    chk("five_bubbles_count", 192'(BubbleCount), 192'(5));
    chk("saturated_count", 192'(s_cnt), 192'(3));

    for (int i = 0; i < 3000; i++) begin
      rand_id();
      Flush = ($urandom_range(0, 15) == 0);
      Hold  = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; Flush = 1'b0; Hold = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
